// File: rtl/sqrt_pkg.sv
// Shared definitions for the iterative square-root engine.
//   state_t    : engine FSM encoding (IDLE -> CALC -> DONE -> IDLE)
//   DEF_*      : default widths for the magnitude-FSM datapath
//   iter_count : number of radix-4 iterations (one root bit each) for a radicand width
package sqrt_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_OUT_W  = 24;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Two radicand bits are consumed per iteration, giving one root bit.
  function automatic int iter_count(input int data_w);
    return data_w / 2;
  endfunction

endpackage

// File: rtl/sqrt_step.sv
// One radix-4 restoring square-root iteration, purely combinational.
//   rem_in   : partial remainder (ROOT_W+2 bits)
//   root_in  : partial root (ROOT_W bits)
//   bits     : next two radicand bits, MSB first
//   rem_out  : updated remainder
//   root_out : updated root (one new LSB appended)
module sqrt_step #(
  parameter int ROOT_W = 16
) (
  input  logic [ROOT_W+1:0] rem_in,
  input  logic [ROOT_W-1:0] root_in,
  input  logic [1:0]        bits,
  output logic [ROOT_W+1:0] rem_out,
  output logic [ROOT_W-1:0] root_out
);

  localparam int RW = ROOT_W + 2;

  logic [RW-1:0] rem_sh;
  logic [RW-1:0] trial;
  logic          ge;

  // The remainder never exceeds 2*root, so the two bits shifted out of the
  // top are always zero and RW bits hold the shifted value exactly.
  assign rem_sh = RW'({rem_in, bits});
  assign trial  = RW'({root_in, 2'b01});
  assign ge     = (rem_sh >= trial);

  assign rem_out  = ge ? (rem_sh - trial) : rem_sh;
  assign root_out = ROOT_W'({root_in, ge});

endmodule

// File: rtl/sqrt_iter_engine.sv
// Iterative unsigned integer square root, one root bit per clock.
// Sits downstream of the magnitude FSM; replaces the vendor CORDIC sqrt core.
//   clk, rst  : clock, asynchronous active-high reset
//   in_valid  : operand valid, accepted only while in_ready=1
//   in_data   : unsigned radicand (DATA_W)
//   in_ready  : engine idle
//   out_valid : one-cycle pulse, out_data/out_rem hold a new result
//   out_data  : root (floor, or nearest when ROUND=1), zero-extended to OUT_W
//   out_rem   : floor remainder x - floor(sqrt(x))^2
//   busy      : iterations in progress
// Latency: accept at edge N, out_valid high after edge N+DATA_W/2+1.
module sqrt_iter_engine
  import sqrt_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int OUT_W  = DEF_OUT_W,
  parameter int ROUND  = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [OUT_W-1:0]  out_data,
  output logic [DATA_W/2:0] out_rem,
  output logic              busy
);

  localparam int H     = iter_count(DATA_W);
  localparam int RW    = H + 2;
  localparam int CNT_W = (H > 1) ? $clog2(H) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(H - 1);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] rad;
  logic [H-1:0]      root;
  logic [RW-1:0]     rem;

  logic [RW-1:0]     step_rem;
  logic [H-1:0]      step_root;
  logic              rnd_up;

  sqrt_step #(.ROOT_W(H)) u_step (
    .rem_in   (rem),
    .root_in  (root),
    .bits     (rad[DATA_W-1 -: 2]),
    .rem_out  (step_rem),
    .root_out (step_root)
  );

  // x - r^2 > r  <=>  x > (r+0.5)^2 for integers, so this is round-to-nearest.
  assign rnd_up = (ROUND != 0) && (rem > RW'(root));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_rem   <= '0;
      cnt       <= '0;
      rad       <= '0;
      root      <= '0;
      rem       <= '0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            rad      <= in_data;
            rem      <= '0;
            root     <= '0;
            cnt      <= CNT_LAST;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= S_CALC;
          end
        end
        S_CALC: begin
          rem  <= step_rem;
          root <= step_root;
          rad  <= rad << 2;
          if (cnt == '0) begin
            busy  <= 1'b0;
            state <= S_DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_DONE: begin
          // Widened to OUT_W before the add so an all-ones radicand rounds
          // up to 2^(DATA_W/2) instead of wrapping.
          out_data  <= OUT_W'(root) + OUT_W'(rnd_up);
          out_rem   <= rem[H:0];
          out_valid <= 1'b1;
          in_ready  <= 1'b1;
          state     <= S_IDLE;
        end
        default: begin
          in_ready <= 1'b1;
          busy     <= 1'b0;
          state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sqrt_iter_engine.sv
module tb_sqrt_iter_engine;

  localparam int DATA_W = 32;
  localparam int OUT_W  = 24;
  localparam int LAT    = DATA_W/2 + 1;
  localparam int SPACE  = DATA_W/2 + 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;

  logic              ir0, ov0, bz0, ir1, ov1, bz1;
  logic [OUT_W-1:0]  od0, od1;
  logic [DATA_W/2:0] or0, or1;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  sqrt_iter_engine #(.DATA_W(DATA_W), .OUT_W(OUT_W), .ROUND(0)) u_trunc (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(ir0), .out_valid(ov0), .out_data(od0), .out_rem(or0), .busy(bz0)
  );

  sqrt_iter_engine #(.DATA_W(DATA_W), .OUT_W(OUT_W), .ROUND(1)) u_round (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(ir1), .out_valid(ov1), .out_data(od1), .out_rem(or1), .busy(bz1)
  );

  typedef struct {
    logic [DATA_W-1:0] x;
    longint            fl;
    longint            rem;
    longint            rnd;
  } vec_t;

  // Reference: floor root by binary search over r*r <= x.
  function automatic longint ref_floor(input longint x);
    longint lo = 0, hi = 65536, mid;
    while (lo < hi) begin
      mid = (lo + hi + 1) / 2;
      if (mid * mid <= x) lo = mid;
      else hi = mid - 1;
    end
    return lo;
  endfunction

  // Nearest root: round up when x lies above (r + 1/2)^2, i.e. 4x > (2r+1)^2.
  function automatic longint ref_round(input longint x);
    longint r = ref_floor(x);
    return (4 * x > (2*r + 1) * (2*r + 1)) ? r + 1 : r;
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Present one operand, wait for its result and check both instances.
  task automatic run_op(input logic [DATA_W-1:0] x, input longint e_fl,
                        input longint e_rem, input longint e_rnd, input string tag);
    int t = 0;
    int lat = 0;
    logic [OUT_W-1:0]  hold_d;
    logic [DATA_W/2:0] hold_r;
    while (!ir0 && t < 100) begin @(negedge clk); t++; end
    if (!ir0) chk({tag, "_ready_timeout"}, 0, 1);
    in_valid = 1'b1;
    in_data  = x;
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = $urandom;
    while (!ov0 && lat < 60) begin
      @(negedge clk);
      lat++;
      if (lat == 8) chk({tag, "_busy_mid"}, {bz0, ir0}, 2'b10);
    end
    chk({tag, "_latency"}, lat, LAT);
    chk({tag, "_root_floor"}, od0, e_fl);
    chk({tag, "_rem_floor"}, or0, e_rem);
    chk({tag, "_root_round"}, od1, e_rnd);
    chk({tag, "_rem_round"}, or1, e_rem);
    chk({tag, "_pulse_sync"}, {ov1, bz0}, 2'b10);
    hold_d = od0;
    hold_r = or0;
    @(negedge clk);
    chk({tag, "_pulse_one_cycle"}, {ov0, ov1}, 2'b00);
    chk({tag, "_hold"}, {hold_d, hold_r}, {od0, or0});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[$];
    int acc_cyc[$];
    longint res[$];
    int ovcnt;

    tbl.push_back('{32'd0,          0,     0,      0});
    tbl.push_back('{32'd25,         5,     0,      5});
    tbl.push_back('{32'd17,         4,     1,      4});
    tbl.push_back('{32'd8,          2,     4,      3});
    tbl.push_back('{32'd6,          2,     2,      2});
    tbl.push_back('{32'hFFFFFFFF,   65535, 131070, 65536});
    tbl.push_back('{32'd1,          1,     0,      1});
    tbl.push_back('{32'd3,          1,     2,      2});
    tbl.push_back('{32'd15,         3,     6,      4});
    tbl.push_back('{32'd16,         4,     0,      4});
    tbl.push_back('{32'hFFFE0001,   65535, 0,      65535});

    rst = 1'b1; in_valid = 1'b0; in_data = '0;
    @(negedge clk);
    chk("reset_state", {ir0, ov0, bz0, od0, or0}, {1'b1, 1'b0, 1'b0, 24'd0, 17'd0});
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    foreach (tbl[i])
      run_op(tbl[i].x, tbl[i].fl, tbl[i].rem, tbl[i].rnd, $sformatf("tbl%0d", i));

    // Reset in the middle of a calculation: immediate reset values, no late pulse.
    in_valid = 1'b1; in_data = 32'd1000;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midcalc_reset", {ir0, ov0, bz0, od0, or0, ir1, od1},
        {1'b1, 1'b0, 1'b0, 24'd0, 17'd0, 1'b1, 24'd0});
    @(negedge clk);
    rst = 1'b0;
    ovcnt = 0;
    repeat (25) begin
      @(negedge clk);
      if (ov0 || ov1) ovcnt++;
    end
    chk("midcalc_no_pulse", ovcnt, 0);

    // in_valid held high, junk data during CALC, two operands back-to-back.
    in_valid = 1'b1;
    for (int cyc = 0; cyc < 60; cyc++) begin
      if (ov0) res.push_back(od0);
      if (acc_cyc.size() >= 2 && !ir0) in_valid = 1'b0;
      if (in_valid && ir0) begin
        in_data = (acc_cyc.size() == 0) ? 32'd100 : 32'd144;
        acc_cyc.push_back(cyc);
      end else begin
        in_data = $urandom;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("b2b_accepts", acc_cyc.size(), 2);
    chk("b2b_results", res.size(), 2);
    if (acc_cyc.size() == 2) chk("b2b_spacing", acc_cyc[1] - acc_cyc[0], SPACE);
    if (res.size() == 2) begin
      chk("b2b_first", res[0], 10);
      chk("b2b_second", res[1], 12);
    end

    // Random sweep against the reference model.
    for (int k = 0; k < 40; k++) begin
      logic [DATA_W-1:0] x;
      longint r;
      x = (k % 3 == 0) ? DATA_W'($urandom_range(0, 1000)) : $urandom;
      r = ref_floor(longint'(x));
      run_op(x, r, longint'(x) - r * r, ref_round(longint'(x)), $sformatf("rnd%0d", k));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
